// File: rtl/fifo_serializer.sv
// Pulls 9-bit words from an upstream FIFO and sends each one as an asynchronous
// serial frame: start, 9 data bits LSB first, optional even parity, stop.
module fifo_serializer #(
  parameter int CLKS_PER_BIT = 4,
  parameter bit PARITY_EN    = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pin,
  input  logic [8:0] din,
  output logic       sin,
  output logic       sout,
  output logic       frame_done
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [3:0] BIT_LAST = 4'd8;

  state_t     state;
  state_t     state_next;
  logic [7:0] div_q;
  logic [7:0] div_next;
  logic [3:0] bit_q;
  logic [3:0] bit_next;
  logic [8:0] shift_q;
  logic [8:0] shift_next;
  logic       parity_q;
  logic       parity_next;
  logic       sout_next;
  logic       div_wrap;

  assign div_wrap   = (div_q == DIV_LAST);
  assign sin        = reset || (state != IDLE);
  assign frame_done = (state == STOP) && div_wrap;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next  = state;
    div_next    = div_q;
    bit_next    = bit_q;
    shift_next  = shift_q;
    parity_next = parity_q;

    case (state)
      IDLE: begin
        if (pin) begin
          shift_next  = din;
          parity_next = ^din;
          div_next    = '0;
          bit_next    = '0;
          state_next  = START;
        end
      end
      default: begin
        div_next = div_wrap ? 8'd0 : div_q + 8'd1;
        if (div_wrap) begin
          case (state)
            START:  state_next = DATA;
            DATA: begin
              if (bit_q == BIT_LAST) begin
                state_next = PARITY_EN ? PARITY : STOP;
              end else begin
                shift_next = shift_q >> 1;
                bit_next   = bit_q + 4'd1;
              end
            end
            PARITY: state_next = STOP;
            default: state_next = IDLE;
          endcase
        end
      end
    endcase
  end

  // The line level is decoded from the upcoming state so the registered sout
  // lines up with the state it belongs to.
  always_comb begin
    sout_next = 1'b1;
    case (state_next)
      START:   sout_next = 1'b0;
      DATA:    sout_next = shift_next[0];
      PARITY:  sout_next = parity_next;
      default: sout_next = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      sout     <= 1'b1;
    end else begin
      state    <= state_next;
      div_q    <= div_next;
      bit_q    <= bit_next;
      shift_q  <= shift_next;
      parity_q <= parity_next;
      sout     <= sout_next;
    end
  end

endmodule

// File: tb/tb_fifo_serializer.sv
// Scoreboard bench: three serializer lanes with different bit timing and parity
// settings, each fed by a modelled upstream FIFO and checked frame by frame.
module tb_fifo_serializer;

  localparam int NDUT            = 3;
  localparam int CPB [NDUT]      = '{4, 4, 1};
  localparam int PEN [NDUT]      = '{1, 0, 1};
  localparam int DRAIN_CYCLES    = 5000;
  localparam int TIMEOUT_CYCLES  = 40000;
  localparam int RAND_WORDS      = 12;

  typedef struct {
    logic [8:0] word;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks   = 0;
  int n_pass     = 0;
  int cycle      = 0;
  int lanes_done = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input int lane, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL lane%0d %s: got %0h expected %0h (cycle %0d)", lane, name, act, exp, cycle);
  endtask

  // Line level during bit period pos of a frame carrying word w.
  function automatic logic frame_bit(input logic [8:0] w, input int pos, input int pen);
    if (pos == 0) return 1'b0;
    if (pos <= 9) return w[pos-1];
    if (pen != 0 && pos == 10) return ^w;
    return 1'b1;
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_lane
    localparam int N = (11 + PEN[g]) * CPB[g];

    logic       reset;
    logic       pin;
    logic       sin;
    logic       sout;
    logic       frame_done;
    logic [8:0] din;

    logic [8:0] fifo_q [$];
    exp_t       exp_q [$];
    int         busy       = 0;
    bit         edge_reset = 1'b0;
    bit         pop_req    = 1'b0;

    fifo_serializer #(
      .CLKS_PER_BIT(CPB[g]),
      .PARITY_EN   (PEN[g] != 0)
    ) u_dut (
      .clock     (clk),
      .reset     (reset),
      .pin       (pin),
      .din       (din),
      .sin       (sin),
      .sout      (sout),
      .frame_done(frame_done)
    );

    task automatic wait_idle();
      for (int t = 0; t < DRAIN_CYCLES && (fifo_q.size() != 0 || busy != 0); t++) begin
        @(posedge clk);
        #2;
      end
      check(g, "drain", (fifo_q.size() == 0 && busy == 0), 1);
    endtask

    // Upstream FIFO reacts to the stall seen before the edge.
    always @(negedge clk) pop_req = !sin && pin;

    // Reference model: inputs held across an edge decide what that edge does.
    initial begin
      exp_t e;
      pin = 1'b0;
      din = '0;
      forever begin
        @(posedge clk);
        #1;
        edge_reset = reset;
        if (edge_reset) begin
          busy = 0;
        end else if (busy > 0) begin
          busy--;
        end else if (pin) begin
          busy   = N;
          e.word = din;
          e.cyc  = cycle;
          exp_q.push_back(e);
        end
        if (pop_req && fifo_q.size() > 0) void'(fifo_q.pop_front());
        if (busy == 0) begin
          pin = (fifo_q.size() > 0);
          din = pin ? fifo_q[0] : 9'($urandom);
        end else begin
          pin = 1'($urandom);
          din = 9'($urandom);
        end
      end
    end

    // Monitor: a falling line starts a frame, which is compared cycle by cycle.
    initial begin
      exp_t cur;
      int   idx;
      bit   in_frame;
      idx      = 0;
      in_frame = 1'b0;
      cur.word = '0;
      cur.cyc  = 0;
      forever begin
        @(negedge clk);
        check(g, "sin", sin, (reset || busy > 0));
        if (edge_reset) in_frame = 1'b0;
        if (!in_frame && !edge_reset && sout === 1'b0 && exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          check(g, "frame start cycle", cycle, cur.cyc);
          in_frame = 1'b1;
          idx      = 0;
        end
        if (in_frame) begin
          check(g, "sout", sout, frame_bit(cur.word, idx / CPB[g], PEN[g]));
          check(g, "frame_done", frame_done, (idx == N - 1));
          idx++;
          if (idx == N) in_frame = 1'b0;
        end else begin
          check(g, "idle sout", sout, 1);
          check(g, "idle frame_done", frame_done, 0);
        end
      end
    end

    // Stimulus: directed words, mid-frame reset, long idle, then random traffic.
    initial begin
      reset = 1'b1;
      fifo_q.push_back(9'h1A5);
      repeat (3) @(posedge clk);
      #2 reset = 1'b0;
      wait_idle();

      fifo_q.push_back(9'h000);
      fifo_q.push_back(9'h1FF);
      fifo_q.push_back(9'h055);
      wait_idle();
      fifo_q.push_back(9'h0F0);
      wait_idle();
      fifo_q.push_back(9'h101);
      wait_idle();

      // Reset lands in the first cycle of data bit 4.
      fifo_q.push_back(9'($urandom));
      for (int t = 0; t < 100 && busy == 0; t++) begin
        @(posedge clk);
        #2;
      end
      repeat (5 * CPB[g]) @(posedge clk);
      #2 reset = 1'b1;
      @(posedge clk);
      #2 reset = 1'b0;
      wait_idle();

      repeat (100) @(posedge clk);
      #2;

      for (int i = 0; i < RAND_WORDS; i++) begin
        fifo_q.push_back(9'($urandom));
        if ($urandom_range(0, 3) == 0) fifo_q.push_back(9'($urandom));
        repeat ($urandom_range(0, N + 10)) @(posedge clk);
        #2;
      end
      wait_idle();

      @(negedge clk);
      check(g, "frames left", exp_q.size(), 0);
      lanes_done++;
    end
  end

  initial begin
    for (int t = 0; t < TIMEOUT_CYCLES && lanes_done != NDUT; t++) @(posedge clk);
    if (lanes_done != NDUT) begin
      n_checks++;
      $display("FAIL timeout: lanes done %0d expected %0d", lanes_done, NDUT);
    end
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_serializer.md
FIFO_SERIALIZER -- requirements
Module: fifo_serializer

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 4, clock cycles per serial bit; legal range 1..255.
REQ-002 Parameter: PARITY_EN, default 1, 1 = even-parity bit inserted after data, 0 = no parity bit.
REQ-003 clock  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 pin  input  1  word available; driven by the upstream FIFO not-empty flag (pout).
REQ-006 din  input  9  word from the upstream FIFO read port (dout); valid whenever pin=1.
REQ-007 sin  output  1  stall to the upstream FIFO; 0 = this block consumes din at the current edge when pin=1.
REQ-008 sout  output  1  serial line, idle high, registered.
REQ-009 frame_done  output  1  one-cycle pulse in the last cycle of each stop bit.

Function
REQ-010 FSM states: IDLE, START, DATA, PARITY, STOP; state, bit counter, divider counter and shift register are registered.
REQ-011 sin = 1 when reset=1 or state != IDLE; sin = 0 only in IDLE with reset=0.
REQ-012 IDLE, pin=1 at rising edge: load din into 9-bit shift register, clear divider and bit counter, go to START; the upstream FIFO advances on the same edge.
REQ-013 IDLE, pin=0: remain in IDLE, sout=1, no capture.
REQ-014 Divider counts 0..CLKS_PER_BIT-1 in every non-IDLE state; state or bit advances only on the cycle where divider = CLKS_PER_BIT-1, and the divider then wraps to 0.
REQ-015 START: sout=0 for CLKS_PER_BIT cycles, then DATA.
REQ-016 DATA: sout = shift register bit 0; after each bit period, shift right by one and increment bit counter; after the 9th bit (counter = 8 at wrap), go to PARITY if PARITY_EN=1, else STOP.
REQ-017 PARITY: sout = XOR of the 9 captured data bits (even parity: total ones including parity is even), for CLKS_PER_BIT cycles, then STOP.
REQ-018 STOP: sout=1 for CLKS_PER_BIT cycles; frame_done=1 in the final cycle only; then IDLE.
REQ-019 Parity is computed from the captured word at load time, not from the shifting register.
REQ-020 sout reflects the current state with exactly one cycle of register latency: the first START low appears on the cycle after the capture edge.
REQ-021 Frame length = (11 + PARITY_EN) x CLKS_PER_BIT cycles; minimum capture-to-capture spacing = frame length + 1 (one mandatory IDLE cycle).
REQ-022 din and pin changes outside IDLE shall have no effect on the frame in progress.
REQ-023 CLKS_PER_BIT=1: every state lasts exactly one cycle; no divider-related skipped or repeated bits.

Reset
REQ-024 On a rising edge with reset=1: state=IDLE, sout=1, frame_done=0, counters=0, shift register=0.
REQ-025 Reset asserted mid-frame aborts the frame at the next edge; the partially sent word is lost and not re-requested.
REQ-026 sin=1 throughout reset assertion, so no word is consumed during reset; the first capture can occur on the first edge after reset deasserts, with pin=1.

Verification
REQ-027 Reset, then pin=1, din=9'h1A5, CLKS_PER_BIT=4, PARITY_EN=1 -> sout sequence per 4-cycle bit: 0, 1,0,1,0,0,1,0,1,1, parity 1, stop 1; frame_done pulses in cycle 48 after capture; sin high for 48 cycles.
REQ-028 pin held 1 with three queued words (9'h000, 9'h1FF, 9'h055) -> captures exactly 49 cycles apart; parity bits 0, 1, 0; exactly three sin-low capture edges.
REQ-029 PARITY_EN=0, din=9'h0F0 -> 11 bit periods: 0, 0,0,0,0,1,1,1,1,0, 1; frame_done at cycle 44.
REQ-030 CLKS_PER_BIT=1, din=9'h101 -> sout 0,1,0,0,0,0,0,0,0,1,0,1 on consecutive cycles, then IDLE.
REQ-031 reset pulsed for 1 cycle during DATA bit 4 -> next cycle sout=1, sin=0 (if reset low), state IDLE; no frame_done; the next pin=1 starts a clean frame.
REQ-032 pin=0 for 100 cycles after reset -> sout=1, sin=0 and frame_done=0 throughout.
